alu_issue_ctrl: RTL and testbench

- Sequential issue/capture controller that sits directly around the 4-bit combinational ALU.
- Accepts an operation request over a valid/ready handshake and registers the operands and operator that drive the ALU's n1/n2/operator inputs.
- Captures the ALU's X/CCR outputs into a result register presented downstream with valid/ready.
- Holds a 4-bit accumulator that can replace n1, giving chained operations, plus a completed-operation counter.

---
 rtl/alu_issue_ctrl_if.sv | 36 +++
 rtl/alu_issue_ctrl.sv | 81 ++++++++
 tb/tb_alu_issue_ctrl.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/alu_issue_ctrl_if.sv
// alu_issue_ctrl_if: request, ALU and result signals of the issue controller.
// slave is the controller side, master drives requests and models the ALU.
interface alu_issue_ctrl_if #(
   parameter int WIDTH = 4,
   parameter int OP_W  = 3,
   parameter int CNT_W = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic [OP_W-1:0]  in_op;
   logic             in_acc;
   logic [WIDTH-1:0] n1;
   logic [WIDTH-1:0] n2;
   logic [OP_W-1:0]  operator;
   logic [WIDTH-1:0] X;
   logic [1:0]       CCR;
   logic             res_valid;
   logic             res_ready;
   logic [WIDTH-1:0] res;
   logic [1:0]       res_ccr;
   logic [WIDTH-1:0] acc;
   logic [CNT_W-1:0] op_count;
   logic             flag_clr;
   logic             sticky_c;
   logic             sticky_v;
   modport slave (
      input  in_valid, in_a, in_b, in_op, in_acc, X, CCR, res_ready, flag_clr,
      output in_ready, n1, n2, operator, res_valid, res, res_ccr, acc, op_count, sticky_c, sticky_v
   );
   modport master (
      output in_valid, in_a, in_b, in_op, in_acc, X, CCR, res_ready, flag_clr,
      input  in_ready, n1, n2, operator, res_valid, res, res_ccr, acc, op_count, sticky_c, sticky_v
   );
endinterface

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: registers ALU operands, captures X/CCR into a result/accumulator.
// Optional sticky carry/overflow flags under ALU_STICKY_FLAGS_EN.
module alu_issue_ctrl #(
   parameter int WIDTH = 4,
   parameter int OP_W  = 3,
   parameter int CNT_W = 8
) (
   input logic         clk,
   input logic         rst,
   alu_issue_ctrl_if.slave bus
);
   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
   state_t           state_q, state_d;
   logic [WIDTH-1:0] n1_q, n2_q, res_q, acc_q;
   logic [OP_W-1:0]  op_q;
   logic [1:0]       ccr_q;
   logic [CNT_W-1:0] cnt_q;
   logic             in_ready, accept, capture;
   always_comb begin
      in_ready = !rst && (state_q == IDLE || (state_q == DONE && bus.res_ready));
      accept   = bus.in_valid && in_ready;
      capture  = state_q == EXEC;
      state_d  = accept ? EXEC
               : capture ? DONE
               : (state_q == DONE && bus.res_ready) ? IDLE : state_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         n1_q    <= '0;
         n2_q    <= '0;
         op_q    <= '0;
         res_q   <= '0;
         ccr_q   <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            n1_q <= bus.in_acc ? acc_q : bus.in_a;
            n2_q <= bus.in_b;
            op_q <= bus.in_op;
         end
         if (capture) begin
            res_q <= bus.X;
            ccr_q <= bus.CCR;
            acc_q <= bus.X;
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end
`ifdef ALU_STICKY_FLAGS_EN
   logic sticky_c_q, sticky_v_q;
   // a capture in the same cycle as flag_clr still sets the flag
   always_ff @(posedge clk) begin
      if (rst) begin
         sticky_c_q <= 1'b0;
         sticky_v_q <= 1'b0;
      end else begin
         sticky_c_q <= (bus.flag_clr ? 1'b0 : sticky_c_q) | (capture & bus.CCR[1]);
         sticky_v_q <= (bus.flag_clr ? 1'b0 : sticky_v_q) | (capture & bus.CCR[0]);
      end
   end
   assign bus.sticky_c = sticky_c_q;
   assign bus.sticky_v = sticky_v_q;
`else
   logic unused_flag_clr;
   assign unused_flag_clr = bus.flag_clr;
   assign bus.sticky_c    = 1'b0;
   assign bus.sticky_v    = 1'b0;
`endif
   assign bus.in_ready  = in_ready;
   assign bus.n1        = n1_q;
   assign bus.n2        = n2_q;
   assign bus.operator  = op_q;
   assign bus.res_valid = state_q == DONE;
   assign bus.res       = res_q;
   assign bus.res_ccr   = ccr_q;
   assign bus.acc       = acc_q;
   assign bus.op_count  = cnt_q;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed checks of alu_issue_ctrl with a behavioural 4-bit ALU attached.
module tb_alu_issue_ctrl;
`ifdef ALU_STICKY_FLAGS_EN
   localparam logic STICKY = 1'b1;
`else
   localparam logic STICKY = 1'b0;
`endif
   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   failures = 0;
   alu_issue_ctrl_if #(.WIDTH(4), .OP_W(3), .CNT_W(8)) bus ();
   alu_issue_ctrl #(.WIDTH(4), .OP_W(3), .CNT_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   // reference ALU: CCR = {carry, overflow}, forced 00 outside add/sub
   always_comb begin
      logic [4:0] s;
      s = '0;
      bus.X   = '0;
      bus.CCR = 2'b00;
      case (bus.operator)
         3'b000: begin
            s = {1'b0, bus.n1} + {1'b0, bus.n2};
            bus.X   = s[3:0];
            bus.CCR = {s[4], (bus.n1[3] == bus.n2[3]) && (s[3] != bus.n1[3])};
         end
         3'b001: begin
            s = {1'b0, bus.n1} - {1'b0, bus.n2};
            bus.X   = s[3:0];
            bus.CCR = {s[4], (bus.n1[3] != bus.n2[3]) && (s[3] != bus.n1[3])};
         end
         3'b010: bus.X = bus.n1 << 1;
         3'b011: bus.X = -bus.n1;
         3'b100: bus.X = ~bus.n1;
         3'b101: bus.X = bus.n1 & bus.n2;
         3'b110: bus.X = bus.n1 | bus.n2;
         default: bus.X = bus.n1 ^ bus.n2;
      endcase
   end
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic req(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op, input logic use_acc);
      bus.in_valid = 1'b1;
      bus.in_a     = a;
      bus.in_b     = b;
      bus.in_op    = op;
      bus.in_acc   = use_acc;
   endtask
   initial begin
      rst = 1'b1;
      bus.res_ready = 1'b0;
      bus.flag_clr  = 1'b0;
      req(4'h5, 4'h5, 3'b000, 1'b0);
      tick();
      tick();
      chk("rst_in_ready", 32'(bus.in_ready), 0);
      chk("rst_res_valid", 32'(bus.res_valid), 0);
      chk("rst_n1", 32'(bus.n1), 0);
      chk("rst_operator", 32'(bus.operator), 0);
      chk("rst_acc", 32'(bus.acc), 0);
      chk("rst_op_count", 32'(bus.op_count), 0);
      rst = 1'b0;
      bus.in_valid = 1'b0;
      #1;
      chk("idle_in_ready", 32'(bus.in_ready), 1);
      // add 7+9 -> 0 with carry
      req(4'h7, 4'h9, 3'b000, 1'b0);
      tick();
      bus.in_valid = 1'b0;
      chk("add_n1", 32'(bus.n1), 7);
      chk("add_n2", 32'(bus.n2), 9);
      chk("exec_in_ready", 32'(bus.in_ready), 0);
      chk("exec_res_valid", 32'(bus.res_valid), 0);
      tick();
      chk("add_res_valid", 32'(bus.res_valid), 1);
      chk("add_res", 32'(bus.res), 0);
      chk("add_ccr", 32'(bus.res_ccr), 2);
      chk("add_acc", 32'(bus.acc), 0);
      chk("add_op_count", 32'(bus.op_count), 1);
      bus.res_ready = 1'b1;
      tick();
      chk("add_drop_valid", 32'(bus.res_valid), 0);
      chk("hold_n1", 32'(bus.n1), 7);
      // accumulate chain from a fresh reset
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         req(4'h0, 4'h3, 3'b000, 1'b1);
         tick();
         bus.in_valid = 1'b0;
         tick();
         chk("acc_res", 32'(bus.res), 32'(3 * i));
      end
      chk("acc_value", 32'(bus.acc), 9);
      chk("acc_op_count", 32'(bus.op_count), 3);
      tick();
      // backpressure then same-cycle handoff
      bus.res_ready = 1'b0;
      req(4'h1, 4'h1, 3'b000, 1'b0);
      tick();
      bus.in_valid = 1'b0;
      tick();
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bp_res_valid", 32'(bus.res_valid), 1);
         chk("bp_res", 32'(bus.res), 2);
         chk("bp_in_ready", 32'(bus.in_ready), 0);
      end
      req(4'hC, 4'hA, 3'b101, 1'b0);
      bus.res_ready = 1'b1;
      #1;
      chk("b2b_in_ready", 32'(bus.in_ready), 1);
      tick();
      bus.in_valid = 1'b0;
      chk("b2b_exec_valid", 32'(bus.res_valid), 0);
      tick();
      chk("b2b_res_valid", 32'(bus.res_valid), 1);
      chk("b2b_res", 32'(bus.res), 8);
      chk("b2b_ccr", 32'(bus.res_ccr), 0);
      chk("b2b_op_count", 32'(bus.op_count), 5);
      tick();
      // reset while in EXEC
      req(4'h2, 4'h2, 3'b000, 1'b0);
      tick();
      bus.in_valid = 1'b0;
      rst = 1'b1;
      tick();
      chk("mid_rst_valid", 32'(bus.res_valid), 0);
      chk("mid_rst_acc", 32'(bus.acc), 0);
      chk("mid_rst_op_count", 32'(bus.op_count), 0);
      rst = 1'b0;
      #1;
      chk("mid_rst_idle", 32'(bus.in_ready), 1);
      tick();
      chk("mid_rst_no_valid", 32'(bus.res_valid), 0);
      // sticky overflow: 7+1 = 8 sets V
      req(4'h7, 4'h1, 3'b000, 1'b0);
      tick();
      bus.in_valid = 1'b0;
      tick();
      chk("stk_res", 32'(bus.res), 8);
      chk("stk_ccr", 32'(bus.res_ccr), 1);
      chk("stk_v_set", 32'(bus.sticky_v), 32'(STICKY));
      req(4'h1, 4'h2, 3'b110, 1'b0);
      tick();
      bus.in_valid = 1'b0;
      tick();
      chk("stk_or_res", 32'(bus.res), 3);
      chk("stk_v_hold", 32'(bus.sticky_v), 32'(STICKY));
      chk("stk_c_clear", 32'(bus.sticky_c), 0);
      bus.flag_clr = 1'b1;
      tick();
      bus.flag_clr = 1'b0;
      chk("stk_v_cleared", 32'(bus.sticky_v), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
